// File: rtl/ldr_sequencer.sv
// Byte-to-word loader: packs HPS ioctl byte writes into 16-bit big-endian word
// writes with byte enables, handshaking each word on ldr_wr/ldr_ack.
module ldr_sequencer #(
   parameter int ADDR_W      = 20,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic              ldr_aen,
   output logic [ADDR_W-2:0] ldr_addr,
   output logic [15:0]       ldr_wdat,
   output logic [1:0]        ldr_be,
   output logic              ldr_wr,
   input  logic              ldr_ack,
   output logic              ldr_done,
   output logic              ldr_err,
   output logic [ADDR_W-1:0] ldr_words
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_WRITE   = 3'd2;
   localparam logic [2:0] S_DONE    = 3'd3;
   localparam logic [2:0] S_ERROR   = 3'd4;

   localparam int              TO_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

   logic [2:0]        state;
   logic              dl_q;
   logic              ack_q;
   logic              dl_ended;
   logic              pend_valid;
   logic [7:0]        pend_byte;
   logic [ADDR_W-2:0] pend_waddr;
   logic              hold_valid;
   logic [7:0]        hold_byte;
   logic [ADDR_W-2:0] hold_waddr;
   logic [TO_W-1:0]   to_cnt;

   logic              dl_rise;
   logic              dl_fall;
   logic              ack_rise;
   logic [ADDR_W-2:0] wr_waddr;
   logic              wr_odd;
   logic              same_word;

   logic              launch;
   logic [ADDR_W-2:0] launch_addr;
   logic [15:0]       launch_wdat;
   logic [1:0]        launch_be;
   logic              take_pend;
   logic              to_hold;
   logic              finish;

   assign dl_rise   = ioctl_download & ~dl_q;
   assign dl_fall   = ~ioctl_download & dl_q;
   assign ack_rise  = ldr_ack & ~ack_q;
   assign wr_waddr  = ioctl_addr[ADDR_W-1:1];
   assign wr_odd    = ioctl_addr[0];
   assign same_word = pend_valid && (pend_waddr == wr_waddr);

   // COLLECT decision: which word (if any) to launch, and what happens to the
   // pending/hold bytes. A pending byte for another word is flushed on its own.
   always_comb begin
      launch      = 1'b0;
      launch_addr = wr_waddr;
      launch_wdat = 16'h0000;
      launch_be   = 2'b00;
      take_pend   = 1'b0;
      to_hold     = 1'b0;
      finish      = 1'b0;
      if (state == S_COLLECT && !dl_rise) begin
         if (ioctl_wr) begin
            if (!wr_odd) begin
               if (pend_valid && !same_word) begin
                  launch      = 1'b1;
                  launch_addr = pend_waddr;
                  launch_wdat = {pend_byte, 8'h00};
                  launch_be   = 2'b10;
                  to_hold     = 1'b1;
               end else begin
                  take_pend = 1'b1;
               end
            end else if (same_word) begin
               launch      = 1'b1;
               launch_wdat = {pend_byte, ioctl_dout};
               launch_be   = 2'b11;
            end else begin
               launch      = 1'b1;
               launch_wdat = {8'h00, ioctl_dout};
               launch_be   = 2'b01;
            end
         end else if (dl_fall || dl_ended) begin
            if (pend_valid) begin
               launch      = 1'b1;
               launch_addr = pend_waddr;
               launch_wdat = {pend_byte, 8'h00};
               launch_be   = 2'b10;
            end else begin
               finish = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= S_IDLE;
         dl_q       <= ioctl_download;
         ack_q      <= ldr_ack;
         dl_ended   <= 1'b0;
         pend_valid <= 1'b0;
         pend_byte  <= 8'h00;
         pend_waddr <= '0;
         hold_valid <= 1'b0;
         hold_byte  <= 8'h00;
         hold_waddr <= '0;
         to_cnt     <= '0;
         ioctl_wait <= 1'b0;
         ldr_aen    <= 1'b0;
         ldr_addr   <= '0;
         ldr_wdat   <= 16'h0000;
         ldr_be     <= 2'b00;
         ldr_wr     <= 1'b0;
         ldr_done   <= 1'b0;
         ldr_err    <= 1'b0;
         ldr_words  <= '0;
      end else begin
         dl_q  <= ioctl_download;
         ack_q <= ldr_ack;
         if (dl_rise) begin
            state      <= S_COLLECT;
            ldr_aen    <= 1'b1;
            ldr_wr     <= 1'b0;
            ioctl_wait <= 1'b0;
            ldr_done   <= 1'b0;
            ldr_err    <= 1'b0;
            ldr_words  <= '0;
            pend_valid <= 1'b0;
            hold_valid <= 1'b0;
            dl_ended   <= 1'b0;
            to_cnt     <= '0;
         end else begin
            case (state)
               S_COLLECT: begin
                  if (dl_fall) dl_ended <= 1'b1;
                  if (take_pend) begin
                     pend_valid <= 1'b1;
                     pend_byte  <= ioctl_dout;
                     pend_waddr <= wr_waddr;
                     ldr_addr   <= wr_waddr;
                  end
                  if (to_hold) begin
                     hold_valid <= 1'b1;
                     hold_byte  <= ioctl_dout;
                     hold_waddr <= wr_waddr;
                  end
                  if (launch) begin
                     state      <= S_WRITE;
                     ldr_addr   <= launch_addr;
                     ldr_wdat   <= launch_wdat;
                     ldr_be     <= launch_be;
                     ldr_wr     <= 1'b1;
                     ioctl_wait <= 1'b1;
                     to_cnt     <= '0;
                     if (launch_be[1]) pend_valid <= 1'b0;
                  end
                  if (finish) begin
                     state    <= S_DONE;
                     ldr_aen  <= 1'b0;
                     ldr_done <= 1'b1;
                     dl_ended <= 1'b0;
                  end
               end
               // Any byte arriving while stalled is lost; flag it but keep the word.
               S_WRITE: begin
                  if (ioctl_wr) ldr_err <= 1'b1;
                  if (dl_fall) dl_ended <= 1'b1;
                  if (ack_rise) begin
                     ldr_wr     <= 1'b0;
                     ioctl_wait <= 1'b0;
                     ldr_words  <= ldr_words + ADDR_W'(1);
                     if (hold_valid) begin
                        pend_valid <= 1'b1;
                        pend_byte  <= hold_byte;
                        pend_waddr <= hold_waddr;
                        ldr_addr   <= hold_waddr;
                        hold_valid <= 1'b0;
                        state      <= S_COLLECT;
                     end else if ((dl_ended || dl_fall) && !pend_valid) begin
                        state    <= S_DONE;
                        ldr_aen  <= 1'b0;
                        ldr_done <= 1'b1;
                        dl_ended <= 1'b0;
                     end else begin
                        state <= S_COLLECT;
                     end
                  end else if (to_cnt == TO_LAST) begin
                     state      <= S_ERROR;
                     ldr_wr     <= 1'b0;
                     ioctl_wait <= 1'b0;
                     ldr_aen    <= 1'b0;
                     ldr_err    <= 1'b1;
                  end else begin
                     to_cnt <= to_cnt + TO_W'(1);
                  end
               end
               S_ERROR: begin
                  if (dl_fall || dl_ended) begin
                     state    <= S_DONE;
                     ldr_done <= 1'b1;
                     dl_ended <= 1'b0;
                  end
               end
               S_IDLE, S_DONE: begin
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ldr_sequencer.sv
// Scoreboard bench for ldr_sequencer: expected word writes are queued as bytes
// are driven and matched when ldr_wr rises.
module tb_ldr_sequencer;

   localparam int ADDR_W      = 20;
   localparam int ACK_TIMEOUT = 16;

   logic              clk_sys = 1'b0;
   logic              reset;
   logic              ioctl_download;
   logic              ioctl_wr;
   logic [ADDR_W-1:0] ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              ioctl_wait;
   logic              ldr_aen;
   logic [ADDR_W-2:0] ldr_addr;
   logic [15:0]       ldr_wdat;
   logic [1:0]        ldr_be;
   logic              ldr_wr;
   logic              ldr_ack;
   logic              ldr_done;
   logic              ldr_err;
   logic [ADDR_W-1:0] ldr_words;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [ADDR_W-2:0] addr;
      logic [15:0]       wdat;
      logic [1:0]        be;
   } wr_exp_t;

   wr_exp_t exp_q[$];
   wr_exp_t mon_e;
   logic    prev_wr = 1'b0;

   always #5 clk_sys = ~clk_sys;

   ldr_sequencer #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(ioctl_wait), .ldr_aen(ldr_aen), .ldr_addr(ldr_addr),
      .ldr_wdat(ldr_wdat), .ldr_be(ldr_be), .ldr_wr(ldr_wr), .ldr_ack(ldr_ack),
      .ldr_done(ldr_done), .ldr_err(ldr_err), .ldr_words(ldr_words)
   );

   // Each new write request is matched against the oldest expected word.
   always @(negedge clk_sys) begin
      if (ldr_wr === 1'b1 && prev_wr !== 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_write: got addr=%h wdat=%h be=%b, want no write", ldr_addr, ldr_wdat, ldr_be);
         end else begin
            mon_e = exp_q.pop_front();
            if ({ldr_addr, ldr_wdat, ldr_be} !== mon_e)
               begin bad++; $display("[TB] FAIL write_word: got addr=%h wdat=%h be=%b, want addr=%h wdat=%h be=%b", ldr_addr, ldr_wdat, ldr_be, mon_e.addr, mon_e.wdat, mon_e.be); end
         end
      end
      prev_wr = ldr_wr;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic send_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      @(negedge clk_sys);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
   endtask

   task automatic start_load();
      @(negedge clk_sys);
      ioctl_download = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic end_load();
      @(negedge clk_sys);
      ioctl_download = 1'b0;
      @(negedge clk_sys);
   endtask

   // Waits (bounded) for ldr_wr, holds off 'delay' cycles counting stalled cycles, then acks.
   task automatic ack_write(input int delay, output bit found, output int wait_hi,
                            output logic wr_after, output logic wait_after);
      found    = 1'b0;
      wait_hi  = 0;
      for (int i = 0; i < 50; i++) begin
         if (ldr_wr === 1'b1) begin found = 1'b1; break; end
         @(negedge clk_sys);
      end
      wr_after   = ldr_wr;
      wait_after = ioctl_wait;
      if (found) begin
         for (int i = 0; i < delay; i++) begin
            if (ioctl_wait === 1'b1 && ldr_wr === 1'b1) wait_hi++;
            @(negedge clk_sys);
         end
         ldr_ack = 1'b1;
         @(negedge clk_sys);
         ldr_ack    = 1'b0;
         wr_after   = ldr_wr;
         wait_after = ioctl_wait;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_dout = 8'h00; ldr_ack = 1'b0;
      repeat (3) @(negedge clk_sys);
      total++;
      if ({ldr_aen, ldr_wr, ioctl_wait, ldr_done, ldr_err} !== 5'b0)
         begin bad++; $display("[TB] FAIL reset_flags: got aen/wr/wait/done/err=%b want 00000", {ldr_aen, ldr_wr, ioctl_wait, ldr_done, ldr_err}); end
      total++;
      if (ldr_addr !== '0 || ldr_wdat !== 16'h0 || ldr_be !== 2'b00 || ldr_words !== '0)
         begin bad++; $display("[TB] FAIL reset_data: got addr=%h wdat=%h be=%b words=%0d want zeros", ldr_addr, ldr_wdat, ldr_be, ldr_words); end
      reset = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic test_word_write();
      bit found; int wait_hi; logic wr_after, wait_after;
      start_load();
      total++;
      if (ldr_aen !== 1'b1) begin bad++; $display("[TB] FAIL word_aen: got %b want 1", ldr_aen); end
      exp_q.push_back({19'd0, 16'h1234, 2'b11});
      send_byte(20'd0, 8'h12);
      total++;
      if (ioctl_wait !== 1'b0 || ldr_wr !== 1'b0) begin bad++; $display("[TB] FAIL word_even_only: got wait=%b wr=%b want 0 0", ioctl_wait, ldr_wr); end
      send_byte(20'd1, 8'h34);
      total++;
      if (ioctl_wait !== 1'b1) begin bad++; $display("[TB] FAIL word_wait_rise: got %b want 1", ioctl_wait); end
      ack_write(3, found, wait_hi, wr_after, wait_after);
      total++;
      if (!found || wait_hi != 3) begin bad++; $display("[TB] FAIL word_wait_hold: got found=%0d stalled=%0d want 1 3", found, wait_hi); end
      total++;
      if (wr_after !== 1'b0 || wait_after !== 1'b0) begin bad++; $display("[TB] FAIL word_wr_drop: got wr=%b wait=%b want 0 0", wr_after, wait_after); end
      total++;
      if (ldr_words !== 20'd1) begin bad++; $display("[TB] FAIL word_count: got %0d want 1", ldr_words); end
      end_load();
      total++;
      if (ldr_done !== 1'b1 || ldr_aen !== 1'b0) begin bad++; $display("[TB] FAIL word_done: got done=%b aen=%b want 1 0", ldr_done, ldr_aen); end
   endtask

   task automatic test_flush_sequence();
      bit found; int wait_hi; logic wr_after, wait_after;
      start_load();
      total++;
      if (ldr_done !== 1'b0 || ldr_words !== '0) begin bad++; $display("[TB] FAIL flush_start_clear: got done=%b words=%0d want 0 0", ldr_done, ldr_words); end
      exp_q.push_back({19'd2, 16'hAA00, 2'b10});
      exp_q.push_back({19'd4, 16'hBBCC, 2'b11});
      send_byte(20'd4, 8'hAA);
      send_byte(20'd8, 8'hBB);
      total++;
      if (ioctl_wait !== 1'b1) begin bad++; $display("[TB] FAIL flush_wait: got %b want 1", ioctl_wait); end
      ack_write(2, found, wait_hi, wr_after, wait_after);
      send_byte(20'd9, 8'hCC);
      ack_write(1, found, wait_hi, wr_after, wait_after);
      total++;
      if (!found) begin bad++; $display("[TB] FAIL flush_second: got found=%0d want 1", found); end
      end_load();
      total++;
      if (ldr_done !== 1'b1 || ldr_aen !== 1'b0 || ldr_words !== 20'd2 || ldr_err !== 1'b0)
         begin bad++; $display("[TB] FAIL flush_end: got done=%b aen=%b words=%0d err=%b want 1 0 2 0", ldr_done, ldr_aen, ldr_words, ldr_err); end
   endtask

   task automatic test_download_end();
      bit found; int wait_hi; logic wr_after, wait_after;
      // odd byte alone
      start_load();
      exp_q.push_back({19'd3, 16'h0055, 2'b01});
      send_byte(20'd7, 8'h55);
      ack_write(0, found, wait_hi, wr_after, wait_after);
      end_load();
      total++;
      if (ldr_done !== 1'b1 || ldr_words !== 20'd1) begin bad++; $display("[TB] FAIL odd_done: got done=%b words=%0d want 1 1", ldr_done, ldr_words); end
      // pending even byte flushed by the fall
      start_load();
      exp_q.push_back({19'd5, 16'h7700, 2'b10});
      send_byte(20'd10, 8'h77);
      end_load();
      total++;
      if (ldr_wr !== 1'b1 || ldr_done !== 1'b0) begin bad++; $display("[TB] FAIL fall_flush_wr: got wr=%b done=%b want 1 0", ldr_wr, ldr_done); end
      ack_write(1, found, wait_hi, wr_after, wait_after);
      total++;
      if (ldr_done !== 1'b1 || ldr_aen !== 1'b0) begin bad++; $display("[TB] FAIL fall_flush_done: got done=%b aen=%b want 1 0", ldr_done, ldr_aen); end
      // fall while a write is outstanding
      start_load();
      exp_q.push_back({19'd1, 16'h0099, 2'b01});
      send_byte(20'd3, 8'h99);
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      total++;
      if (ldr_wr !== 1'b1 || ldr_done !== 1'b0) begin bad++; $display("[TB] FAIL fall_in_write: got wr=%b done=%b want 1 0", ldr_wr, ldr_done); end
      ack_write(2, found, wait_hi, wr_after, wait_after);
      total++;
      if (ldr_done !== 1'b1 || ldr_words !== 20'd1) begin bad++; $display("[TB] FAIL fall_in_write_done: got done=%b words=%0d want 1 1", ldr_done, ldr_words); end
   endtask

   task automatic test_drop_during_wait();
      bit found; int wait_hi; logic wr_after, wait_after;
      start_load();
      exp_q.push_back({19'd6, 16'h1122, 2'b11});
      exp_q.push_back({19'd7, 16'h0033, 2'b01});
      send_byte(20'd12, 8'h11);
      send_byte(20'd13, 8'h22);
      send_byte(20'd14, 8'h99);
      total++;
      if (ldr_err !== 1'b1 || ldr_wr !== 1'b1) begin bad++; $display("[TB] FAIL drop_err: got err=%b wr=%b want 1 1", ldr_err, ldr_wr); end
      ack_write(1, found, wait_hi, wr_after, wait_after);
      send_byte(20'd15, 8'h33);
      ack_write(1, found, wait_hi, wr_after, wait_after);
      end_load();
      total++;
      if (ldr_done !== 1'b1 || ldr_err !== 1'b1 || ldr_words !== 20'd2)
         begin bad++; $display("[TB] FAIL drop_end: got done=%b err=%b words=%0d want 1 1 2", ldr_done, ldr_err, ldr_words); end
   endtask

   task automatic test_timeout();
      int stalled = 0;
      start_load();
      total++;
      if (ldr_err !== 1'b0) begin bad++; $display("[TB] FAIL timeout_start_clear: got err=%b want 0", ldr_err); end
      exp_q.push_back({19'd8, 16'h00AB, 2'b01});
      send_byte(20'd17, 8'hAB);
      for (int i = 0; i < 100; i++) begin
         if (ldr_err === 1'b1) break;
         if (ldr_wr === 1'b1) stalled++;
         @(negedge clk_sys);
      end
      total++;
      if (stalled != ACK_TIMEOUT) begin bad++; $display("[TB] FAIL timeout_len: got %0d write cycles want %0d", stalled, ACK_TIMEOUT); end
      total++;
      if ({ldr_err, ldr_wr, ioctl_wait, ldr_aen} !== 4'b1000)
         begin bad++; $display("[TB] FAIL timeout_error: got err/wr/wait/aen=%b want 1000", {ldr_err, ldr_wr, ioctl_wait, ldr_aen}); end
      send_byte(20'd19, 8'hEE);
      @(negedge clk_sys); ldr_ack = 1'b1;
      @(negedge clk_sys); ldr_ack = 1'b0;
      total++;
      if (ldr_words !== '0 || ldr_wr !== 1'b0 || ldr_done !== 1'b0)
         begin bad++; $display("[TB] FAIL error_absorb: got words=%0d wr=%b done=%b want 0 0 0", ldr_words, ldr_wr, ldr_done); end
      end_load();
      total++;
      if (ldr_done !== 1'b1 || ldr_err !== 1'b1) begin bad++; $display("[TB] FAIL error_done: got done=%b err=%b want 1 1", ldr_done, ldr_err); end
   endtask

   task automatic test_reset_mid_write();
      bit found; int wait_hi; logic wr_after, wait_after;
      start_load();
      exp_q.push_back({19'd10, 16'h00CD, 2'b01});
      send_byte(20'd21, 8'hCD);
      total++;
      if (ldr_wr !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_wr: got %b want 1", ldr_wr); end
      reset = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0;
      total++;
      if ({ldr_aen, ldr_wr, ioctl_wait, ldr_done, ldr_err} !== 5'b0 || ldr_words !== '0 || ldr_be !== 2'b00 || ldr_wdat !== 16'h0 || ldr_addr !== '0)
         begin bad++; $display("[TB] FAIL rst_mid_write: got aen/wr/wait/done/err=%b words=%0d be=%b wdat=%h addr=%h want all 0", {ldr_aen, ldr_wr, ioctl_wait, ldr_done, ldr_err}, ldr_words, ldr_be, ldr_wdat, ldr_addr); end
      repeat (3) @(negedge clk_sys);
      send_byte(20'd24, 8'h01);
      send_byte(20'd25, 8'h02);
      total++;
      if (ldr_aen !== 1'b0 || ldr_wr !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_restart: got aen=%b wr=%b want 0 0", ldr_aen, ldr_wr); end
      end_load();
      total++;
      if (ldr_aen !== 1'b0 || ldr_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_fall_idle: got aen=%b done=%b want 0 0", ldr_aen, ldr_done); end
      start_load();
      total++;
      if (ldr_aen !== 1'b1) begin bad++; $display("[TB] FAIL rst_new_start: got aen=%b want 1", ldr_aen); end
      exp_q.push_back({19'd11, 16'h5678, 2'b11});
      send_byte(20'd22, 8'h56);
      send_byte(20'd23, 8'h78);
      ack_write(1, found, wait_hi, wr_after, wait_after);
      end_load();
      total++;
      if (ldr_done !== 1'b1 || ldr_words !== 20'd1) begin bad++; $display("[TB] FAIL rst_reload: got done=%b words=%0d want 1 1", ldr_done, ldr_words); end
   endtask

   initial begin
      test_reset();
      test_word_write();
      test_flush_sequence();
      test_download_end();
      test_drop_during_wait();
      test_timeout();
      test_reset_mid_write();
      repeat (2) @(negedge clk_sys);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL missing_writes: got %0d unmatched want 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ldr_sequencer.md
LDR_SEQUENCER -- requirements
Module: ldr_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, byte-address width of the loader port.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1023, maximum cycles ldr_wr waits for ldr_ack.
REQ-003 SHALL have port clk_sys  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port ioctl_download  in  1  HPS download window.
REQ-006 SHALL have port ioctl_wr  in  1  one-cycle byte strobe.
REQ-007 SHALL have port ioctl_addr  in  ADDR_W  byte address.
REQ-008 SHALL have port ioctl_dout  in  8  byte data.
REQ-009 SHALL have port ioctl_wait  out  1  stall request to HPS.
REQ-010 SHALL have port ldr_aen  out  1  loader owns the memory port.
REQ-011 SHALL have port ldr_addr  out  ADDR_W-1  word address.
REQ-012 SHALL have port ldr_wdat  out  16  word data; the even byte is in [15:8] (68000 big-endian).
REQ-013 SHALL have port ldr_be  out  2  byte enables: [1] = even byte, [0] = odd byte.
REQ-014 SHALL have port ldr_wr  out  1  write request, level-held until acknowledged.
REQ-015 SHALL have port ldr_ack  in  1  write acknowledge; a pulse of one or more cycles.
REQ-016 SHALL have port ldr_done  out  1  load finished.
REQ-017 SHALL have port ldr_err  out  1  an acknowledge timeout occurred.
REQ-018 SHALL have port ldr_words  out  ADDR_W  count of words written in the current load.

Function
REQ-019 States SHALL be IDLE, COLLECT, WRITE, DONE and ERROR.
REQ-020 Download start SHALL be detected as a rising edge of ioctl_download, taken from a registered copy of it.
- A download start in any state SHALL go to COLLECT and clear ldr_done, ldr_err, ldr_words and the pending byte.
REQ-021 In COLLECT, an even-address ioctl_wr SHALL:
- store the byte as pending-high;
- latch ldr_addr = ioctl_addr[ADDR_W-1:1].
REQ-022 In COLLECT, an odd-address ioctl_wr SHALL:
- go to WRITE with be=11 when the pending-high byte is valid and has the same word address;
- otherwise go to WRITE with be=01, wdat[15:8]=0, and the pending byte unchanged.
REQ-023 An even ioctl_wr while pending-high is valid for a different word SHALL:
- flush the old byte (be=10, wdat[7:0]=0);
- hold the new byte in a hold register;
- promote the held byte to pending-high after the acknowledge.
REQ-024 In WRITE, ldr_wr SHALL be 1 and ldr_addr, ldr_wdat and ldr_be SHALL be stable.
- A rising edge of ldr_ack SHALL drop ldr_wr the next cycle.
- The same edge SHALL increment ldr_words, with wrap at 2^ADDR_W.
- It SHALL then return to COLLECT, or go to DONE if the download has ended.
REQ-025 ioctl_wait SHALL be 1 in the cycle after any ioctl_wr that leads to WRITE and SHALL stay 1 until the state leaves WRITE; ldr_wr never starts and ends in the same cycle.
REQ-026 An ioctl_wr while ioctl_wait=1 SHALL be dropped and SHALL set ldr_err.
REQ-027 When ioctl_download falls in COLLECT with pending-high valid, the block SHALL flush it (be=10) and then go to DONE; with nothing pending it SHALL go to DONE directly.
- A download fall during WRITE SHALL be recorded and acted on after the acknowledge.
REQ-028 ldr_aen SHALL be 1 in COLLECT and WRITE and 0 in all other states.
REQ-029 In DONE, ldr_done SHALL be 1 and SHALL hold until the next download start.
REQ-030 If WRITE lasts ACK_TIMEOUT cycles without an ack edge, the block SHALL go to ERROR.
- ERROR SHALL set ldr_err=1, ldr_wr=0 and ioctl_wait=0.
- ERROR SHALL absorb further ioctl_wr.
- ERROR SHALL go to DONE, with ldr_err kept, when ioctl_download falls.
REQ-031 An ldr_ack edge outside WRITE SHALL be ignored.

Reset
REQ-032 On reset: state=IDLE; ldr_aen, ldr_wr, ioctl_wait, ldr_done and ldr_err SHALL be 0; ldr_addr, ldr_wdat, ldr_be and ldr_words SHALL be 0; pending and hold bytes SHALL be invalid.
REQ-033 During reset the edge register SHALL load the current ioctl_download, so a download already in progress at release does not start a load; a fresh rising edge is required.
REQ-034 Reset asserted during WRITE SHALL drop ldr_wr in the cycle after reset is sampled.

Verification
REQ-035 Bytes 0x12@0, 0x34@1, then ack after 3 cycles -> one write: addr 0, wdat 0x1234, be 11; ldr_words=1; ioctl_wait high for the whole wait.
REQ-036 Bytes 0xAA@4, 0xBB@8, 0xCC@9, then download fall -> writes in order:
- addr 2, 0xAA00, be 10;
- addr 4, 0xBBCC, be 11;
- then ldr_done=1, ldr_aen=0, ldr_words=2.
REQ-037 Single byte 0x55@7, then download fall -> one write: addr 3, 0x0055, be 01; then DONE.
REQ-038 No ack for ACK_TIMEOUT cycles -> ldr_err=1, ldr_wr=0, ioctl_wait=0; after the download falls, ldr_done=1 and ldr_err stays 1.
REQ-039 Reset pulsed mid-WRITE with ioctl_download still high -> IDLE, all outputs 0, no new load until ioctl_download falls and rises again.
REQ-040 ioctl_wr pulsed while ioctl_wait=1 -> the byte is dropped, ldr_err=1, and the in-flight write completes unchanged.
